lsp_select_param: RTL and testbench
===================================

# lsp_select_param

Parametrised weighted-distance codebook search for the LSP quantiser second stage. It forms the residual between the target LSP vector and a selected first-stage codeword over a configurable half of the vector. It then searches NCB second-stage codewords for the minimum weighted squared error and returns the winning index and its distance. It sits inside the LSP quantiser beside the existing first/second-half select logic. It uses its own internal G.729 arithmetic rather than the shared operator ports.

## Interface
Parameters:
- M, 10: LSP vector length.
- SPLIT, 5: first element of the upper half; mode 0 covers j in [0,SPLIT), mode 1 covers [SPLIT,M).
- NCB, 32: second-stage codewords searched.
- RBUF_BASE, 12'h000: data-memory address of target vector rbuf[0].
- WEGT_BASE, 12'h010: data-memory address of weight vector wegt[0].
- CB2_BASE, 12'h000: constant-memory address of cb2[0][0]; row k element j at CB2_BASE + k*M + j.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  half select, captured with start.
- lspcb1Addr  in  12  constant-memory address of first-stage codeword element 0, captured with start.
- memReadAddr  out  12  data-memory read address; data on memIn next cycle.
- memIn  in  32  data-memory read data; [15:0] used.
- constMemAddr  out  12  constant-memory read address; data next cycle.
- constMemIn  in  32  constant-memory read data; [15:0] used.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse, result valid.
- index  out  $clog2(NCB)  winning codeword; held until next start.
- minDist  out  32  winning distance; held until next start.

## Operation
- Let L = range length, lo = range start.
- States: IDLE, RES_REQ, RES_CAP, WGT_CAP, CB_INIT, DIST_REQ, DIST_MUL, DIST_MAC, CMP, DONE.
- Phase 1, per j:
  - RES_REQ issues RBUF_BASE+j and lspcb1Addr+j.
  - RES_CAP stores buf[j] = sub(rbuf[j], cb1[j]) and issues WEGT_BASE+j.
  - WGT_CAP stores w[j].
- Phase 2, per k:
  - CB_INIT clears dist and sets j=lo.
  - DIST_REQ issues the cb2 address.
  - DIST_MUL computes d = sub(buf[j], cb2[k][j]) and t = mult(w[j], d).
  - DIST_MAC computes dist = L_mac(dist, t, d).
  - After the last j, go to CMP: if dist < min (signed, strict), load min and index=k. Equal distances keep the earlier index.
- On start, min is initialised to 32'h7FFFFFFF and index to 0.
- Arithmetic:
  - sub: 16-bit saturating.
  - mult: (a*b)>>>15, saturated; 0x8000*0x8000 gives 0x7FFF.
  - L_mac: sat32(acc + 2*a*b); 0x8000*0x8000 product saturates to 0x7FFFFFFF.
- Unused address outputs are 0.
- start while busy is ignored.
- Reset values: busy=0, done=0, index=0, minDist=32'h7FFFFFFF, memReadAddr=0, constMemAddr=0, state IDLE.
- reset mid-search aborts immediately: no done, outputs return to reset values next cycle.

## Timing
- start sampled high in cycle 0. The search runs RES_REQ..CMP, then DONE; done is high in cycle N = 3L + NCB*(3L+2) + 1.
- Defaults (L=5, NCB=32): N = 560.
- index/minDist update on the CMP edge and are stable when done rises.
- FSM returns to IDLE the cycle after DONE. A new start is accepted in that cycle.

## Configuration
- LSP_SEL_EARLY_EXIT_EN defined: in DIST_MAC, if updated dist >= min and j is not the last element, jump straight to CMP (no update). The result is identical because terms are non-negative and saturation is monotone. Latency becomes data-dependent, at most N.
- Undefined: fixed latency N.

## Structure
- Package lsp_select_pkg: state enum, MAX_32, MIN_16/MAX_16 constants.
- One combinational sub-module, lsp_wdist_unit: sub, mult and L_mac saturation datapath (inputs buf, cb2, w, acc; outputs d, t, newAcc), shared by RES_CAP and DIST stages.

## Test plan
- Exact match: mode=1, all rows far except row 17 equal to residual, cb2 ≠ 0 -> index=17, minDist=0, done in cycle 560, busy high cycles 1..559.
- Tie: rows 3 and 9 identical and best, mode=0 -> index=3.
- Saturation: rbuf=0x7FFF, cb1=0x8000, w=0x7FFF, cb2 row 0 all 0x8000 -> buf=0x7FFF, row 0 dist=0x7FFFFFFF; a row with smaller dist wins.
- All rows saturate to 0x7FFFFFFF -> index=0, minDist=0x7FFFFFFF (strict compare).
- Reset asserted in cycle 100 -> no done, busy=0, index=0 next cycle. A subsequent start completes normally with a correct result.
- With LSP_SEL_EARLY_EXIT_EN: same vectors give identical index/minDist as without it, and done comes before cycle 560 when row 0 is best.

Source files
------------

// File: rtl/lsp_select_pkg.sv
// lsp_select_pkg: shared types, constants and saturation helpers for the
// LSP second-stage weighted-distance codebook search (lsp_select_param).
package lsp_select_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RES_REQ,
        S_RES_CAP,
        S_WGT_CAP,
        S_CB_INIT,
        S_DIST_REQ,
        S_DIST_MUL,
        S_DIST_MAC,
        S_CMP,
        S_DONE
    } state_e;

    localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;
    localparam logic signed [15:0] MAX_16 = 16'sh7FFF;
    localparam logic signed [15:0] MIN_16 = 16'sh8000;

    // Clamp a 32-bit signed value into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(
        input logic signed [31:0] v
    );
        if (v > 32'sd32767) begin
            return MAX_16;
        end else if (v < -32'sd32768) begin
            return MIN_16;
        end else begin
            return v[15:0];
        end
    endfunction

    // Clamp a 33-bit signed sum into the 32-bit signed range.
    function automatic logic signed [31:0] sat32(
        input logic signed [32:0] v
    );
        if (v[32] != v[31]) begin
            return v[32] ? MIN_32 : MAX_32;
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/lsp_select_param_wdist.sv
// lsp_wdist_unit: combinational G.729 arithmetic for the distance search.
// Ports: res_i/cb2_i -> d_o = sub(res_i, cb2_i); w_i -> t_o = mult(w_i, d_o);
//        acc_i, mac_t_i, mac_d_i -> new_acc_o = L_mac(acc_i, mac_t_i, mac_d_i).
module lsp_wdist_unit
    import lsp_select_pkg::*;
(
    input  logic signed [15:0] res_i,
    input  logic signed [15:0] cb2_i,
    input  logic signed [15:0] w_i,
    input  logic signed [31:0] acc_i,
    input  logic signed [15:0] mac_t_i,
    input  logic signed [15:0] mac_d_i,
    output logic signed [15:0] d_o,
    output logic signed [15:0] t_o,
    output logic signed [31:0] new_acc_o
);

    logic signed [31:0] diff;
    logic signed [31:0] prod;
    logic signed [31:0] mac_p;
    logic signed [31:0] mac_l;

    always_comb begin
        diff = $signed({{16{res_i[15]}}, res_i})
             - $signed({{16{cb2_i[15]}}, cb2_i});
        d_o  = sat16(diff);

        prod = $signed({{16{w_i[15]}}, w_i})
             * $signed({{16{d_o[15]}}, d_o});
        // Only 0x8000*0x8000 overflows after the shift.
        t_o  = sat16(prod >>> 15);

        mac_p = $signed({{16{mac_t_i[15]}}, mac_t_i})
              * $signed({{16{mac_d_i[15]}}, mac_d_i});
        // Doubling 0x40000000 is the single L_mult overflow case.
        if (mac_p == 32'sh4000_0000) begin
            mac_l = MAX_32;
        end else begin
            mac_l = mac_p <<< 1;
        end
        new_acc_o = sat32($signed({acc_i[31], acc_i})
                        + $signed({mac_l[31], mac_l}));
    end

endmodule

// File: rtl/lsp_select_param.sv
// lsp_select_param: forms the residual target - cb1 over one half of the
// LSP vector, then searches NCB cb2 rows for the minimum weighted squared
// error. Ports: start/mode/lspcb1Addr request; memReadAddr/memIn and
// constMemAddr/constMemIn one-cycle-latency reads; busy, done pulse,
// index/minDist result (held until next start).
// Option: define LSP_SEL_EARLY_EXIT_EN to abandon a row as soon as its
// partial distance can no longer beat the current minimum.
module lsp_select_param
    import lsp_select_pkg::*;
#(
    parameter int          M         = 10,
    parameter int          SPLIT     = 5,
    parameter int          NCB       = 32,
    parameter logic [11:0] RBUF_BASE = 12'h000,
    parameter logic [11:0] WEGT_BASE = 12'h010,
    parameter logic [11:0] CB2_BASE  = 12'h000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [11:0]              lspcb1Addr,
    output logic [11:0]              memReadAddr,
    input  logic [31:0]              memIn,
    output logic [11:0]              constMemAddr,
    input  logic [31:0]              constMemIn,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NCB)-1:0]   index,
    output logic [31:0]              minDist
);

    localparam int JW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = $clog2(NCB);

    localparam logic [JW-1:0] LO1   = JW'(SPLIT);
    localparam logic [JW-1:0] LAST0 = JW'(SPLIT - 1);
    localparam logic [JW-1:0] LAST1 = JW'(M - 1);
    localparam logic [KW-1:0] KLAST = KW'(NCB - 1);

    state_e             state_q, state_d;
    logic [JW-1:0]      j_q, j_d;
    logic [KW-1:0]      k_q, k_d;
    logic               mode_q, mode_d;
    logic [11:0]        cb1_q, cb1_d;
    logic signed [15:0] buf_q [M];
    logic signed [15:0] buf_d [M];
    logic signed [15:0] w_q [M];
    logic signed [15:0] w_d [M];
    logic signed [15:0] d_q, d_d;
    logic signed [15:0] t_q, t_d;
    logic signed [31:0] dist_q, dist_d;
    logic signed [31:0] min_q, min_d;
    logic [KW-1:0]      idx_q, idx_d;

    logic [JW-1:0]      j_last;
    logic               j_at_last;
    logic signed [15:0] u_res;
    logic signed [15:0] u_cb;
    logic signed [15:0] u_w;
    logic signed [15:0] u_d;
    logic signed [15:0] u_t;
    logic signed [31:0] u_acc;
    logic [11:0]        cb2_addr;
    logic               unused_hi;

    assign unused_hi = ^{memIn[31:16], constMemIn[31:16]};

    always_comb begin
        j_last    = mode_q ? LAST1 : LAST0;
        j_at_last = (j_q == j_last);
        cb2_addr  = CB2_BASE
                  + 12'(int'(k_q) * M + int'(j_q));
        // RES_CAP subtracts cb1 from rbuf; DIST_MUL uses the stored residual.
        u_res = (state_q == S_RES_CAP)
              ? $signed(memIn[15:0]) : buf_q[j_q];
        u_cb  = $signed(constMemIn[15:0]);
        u_w   = w_q[j_q];
    end

    lsp_wdist_unit u_wdist (
        .res_i     (u_res),
        .cb2_i     (u_cb),
        .w_i       (u_w),
        .acc_i     (dist_q),
        .mac_t_i   (t_q),
        .mac_d_i   (d_q),
        .d_o       (u_d),
        .t_o       (u_t),
        .new_acc_o (u_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            cb1_q   <= '0;
            d_q     <= '0;
            t_q     <= '0;
            dist_q  <= '0;
            min_q   <= MAX_32;
            idx_q   <= '0;
            for (int i = 0; i < M; i++) begin
                buf_q[i] <= '0;
                w_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            cb1_q   <= cb1_d;
            d_q     <= d_d;
            t_q     <= t_d;
            dist_q  <= dist_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
            for (int i = 0; i < M; i++) begin
                buf_q[i] <= buf_d[i];
                w_q[i]   <= w_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RES_REQ;
                end
            end
            S_RES_REQ:  state_d = S_RES_CAP;
            S_RES_CAP:  state_d = S_WGT_CAP;
            S_WGT_CAP: begin
                state_d = j_at_last ? S_CB_INIT : S_RES_REQ;
            end
            S_CB_INIT:  state_d = S_DIST_REQ;
            S_DIST_REQ: state_d = S_DIST_MUL;
            S_DIST_MUL: state_d = S_DIST_MAC;
            S_DIST_MAC: begin
                if (j_at_last) begin
                    state_d = S_CMP;
`ifdef LSP_SEL_EARLY_EXIT_EN
                // Terms are non-negative, so this row can no longer win.
                end else if (u_acc >= min_q) begin
                    state_d = S_CMP;
`endif
                end else begin
                    state_d = S_DIST_REQ;
                end
            end
            S_CMP: begin
                state_d = (k_q == KLAST) ? S_DONE : S_CB_INIT;
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        j_d    = j_q;
        k_d    = k_q;
        mode_d = mode_q;
        cb1_d  = cb1_q;
        d_d    = d_q;
        t_d    = t_q;
        dist_d = dist_q;
        min_d  = min_q;
        idx_d  = idx_q;
        for (int i = 0; i < M; i++) begin
            buf_d[i] = buf_q[i];
            w_d[i]   = w_q[i];
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    cb1_d  = lspcb1Addr;
                    j_d    = mode ? LO1 : '0;
                    k_d    = '0;
                    min_d  = MAX_32;
                    idx_d  = '0;
                end
            end
            S_RES_CAP: begin
                buf_d[j_q] = u_d;
            end
            S_WGT_CAP: begin
                w_d[j_q] = $signed(memIn[15:0]);
                if (!j_at_last) begin
                    j_d = j_q + JW'(1);
                end
            end
            S_CB_INIT: begin
                dist_d = '0;
                j_d    = mode_q ? LO1 : '0;
            end
            S_DIST_MUL: begin
                d_d = u_d;
                t_d = u_t;
            end
            S_DIST_MAC: begin
                dist_d = u_acc;
                if (!j_at_last) begin
                    j_d = j_q + JW'(1);
                end
            end
            S_CMP: begin
                // Strict compare keeps the earliest row on ties.
                if (dist_q < min_q) begin
                    min_d = dist_q;
                    idx_d = k_q;
                end
                if (k_q != KLAST) begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        busy         = 1'b1;
        done         = 1'b0;
        memReadAddr  = '0;
        constMemAddr = '0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_RES_REQ: begin
                memReadAddr  = RBUF_BASE + 12'(j_q);
                constMemAddr = cb1_q + 12'(j_q);
            end
            S_RES_CAP: begin
                memReadAddr = WEGT_BASE + 12'(j_q);
            end
            S_DIST_REQ: begin
                constMemAddr = cb2_addr;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign index   = idx_q;
    assign minDist = min_q;

endmodule

// File: tb/tb_lsp_select_param.sv
// tb_lsp_select_param: directed vectors with hand-computed results for
// lsp_select_param, including tie, saturation and mid-search reset cases.
module tb_lsp_select_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] lspcb1Addr = '0;
    logic [11:0] memReadAddr;
    logic [31:0] memIn;
    logic [11:0] constMemAddr;
    logic [31:0] constMemIn;
    logic        busy;
    logic        done;
    logic [4:0]  index;
    logic [31:0] minDist;

    logic [15:0] dmem [0:4095];
    logic [15:0] cmem [0:4095];

    int n_assert = 0;
    int n_fail = 0;
    int lat;
    int bb;
    int bad;

    lsp_select_param dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .lspcb1Addr   (lspcb1Addr),
        .memReadAddr  (memReadAddr),
        .memIn        (memIn),
        .constMemAddr (constMemAddr),
        .constMemIn   (constMemIn),
        .busy         (busy),
        .done         (done),
        .index        (index),
        .minDist      (minDist)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        memIn      <= {16'hA5A5, dmem[memReadAddr]};
        constMemIn <= {16'h5A5A, cmem[constMemAddr]};
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_lat(input string tag,
                             input int l,
                             input bit short_ok);
`ifdef LSP_SEL_EARLY_EXIT_EN
        check(tag, 32'(l > 0 && l <= 560
                       && (!short_ok || l < 560)), 32'd1);
`else
        check(tag, 32'(l), 32'd560);
`endif
    endtask

    // Cycle 0 is the one with start high; a stray start is
    // injected mid-search and must be ignored.
    task automatic run_search(input logic m,
                              input int abort_at,
                              output int l,
                              output int busy_bad);
        busy_bad = 0;
        l = -1;
        @(negedge clk);
        start = 1'b1;
        mode = m;
        lspcb1Addr = 12'h200;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 50) begin
                start = 1'b1;
                mode = ~m;
                lspcb1Addr = 12'h000;
            end
            if (c == abort_at) begin
                reset = 1'b1;
                l = c;
                break;
            end
            if (done) begin
                l = c;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
        end
        start = 1'b0;
    endtask

    function automatic logic [15:0] res(input int j);
        return 16'(800 + 99 * j);
    endfunction

    task automatic load_a();
        for (int j = 0; j < 10; j++) begin
            dmem[j] = 16'(1000 + 100 * j);
            dmem[16 + j] = 16'h4000;
            cmem[12'h200 + j] = 16'(200 + j);
        end
    endtask

    task automatic rows_exact();
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 10; j++)
                cmem[k * 10 + j] = (k == 17) ? res(j)
                                 : res(j) + 16'd1000;
    endtask

    task automatic rows_tie();
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 10; j++)
                cmem[k * 10 + j] = (k == 3 || k == 9)
                                 ? res(j) + 16'd10
                                 : res(j) + 16'd1000;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            dmem[i] = '0;
            cmem[i] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_min", minDist, 32'h7FFFFFFF);
        check("rst_maddr", 32'(memReadAddr), 32'd0);
        check("rst_caddr", 32'(constMemAddr), 32'd0);
        reset = 1'b0;

        load_a();
        rows_exact();
        run_search(1'b1, 0, lat, bb);
        check("exact_index", 32'(index), 32'd17);
        check("exact_min", minDist, 32'd0);
        check_lat("exact_lat", lat, 1'b0);
        check("exact_busy", 32'(bb), 32'd0);

        rows_tie();
        run_search(1'b0, 0, lat, bb);
        check("tie_index", 32'(index), 32'd3);
        check("tie_min", minDist, 32'd500);
        check_lat("tie_lat", lat, 1'b0);

        for (int j = 0; j < 10; j++) begin
            dmem[j] = 16'h7FFF;
            dmem[16 + j] = 16'h7FFF;
            cmem[12'h200 + j] = 16'h8000;
        end
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 10; j++)
                cmem[k * 10 + j] = (k == 0) ? 16'h8000
                                 : (k == 5) ? 16'h7FFD
                                 : 16'h0000;
        run_search(1'b0, 0, lat, bb);
        check("sat_index", 32'(index), 32'd5);
        check("sat_min", minDist, 32'd20);
        check_lat("sat_lat", lat, 1'b0);

        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 10; j++)
                cmem[k * 10 + j] = 16'h8000;
        run_search(1'b0, 0, lat, bb);
        check("allsat_index", 32'(index), 32'd0);
        check("allsat_min", minDist, 32'h7FFFFFFF);
        check_lat("allsat_lat", lat, 1'b1);

        load_a();
        rows_tie();
        run_search(1'b0, 100, lat, bb);
        check("abort_reached", 32'(lat), 32'd100);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_index", 32'(index), 32'd0);
        check("abort_min", minDist, 32'h7FFFFFFF);
        check("abort_maddr", 32'(memReadAddr), 32'd0);
        check("abort_caddr", 32'(constMemAddr), 32'd0);
        reset = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("abort_idle", 32'(bad), 32'd0);

        rows_exact();
        run_search(1'b1, 0, lat, bb);
        check("rerun_index", 32'(index), 32'd17);
        check("rerun_min", minDist, 32'd0);
        check_lat("rerun_lat", lat, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
